// File: rtl/eth_tx_dma_reader_pkg.sv
// rtl/eth_tx_dma_reader_pkg.sv - shared ethernet DMA types, constants and tkeep helper
// Contents: eth_tx_dma_state_e (reader FSM states), eth_dword_bytes_gp (bytes per
// memory/AXIS beat), eth_tkeep_from_rem() (byte enables for a partial final beat).
package eth_tx_dma_reader_pkg;

    typedef enum logic [1:0] {
        e_idle = 2'd0,
        e_run  = 2'd1,
        e_done = 2'd2
    } eth_tx_dma_state_e;

    localparam int eth_dword_bytes_gp = 8;

    // rem is the byte count of the final beat modulo 8; zero means a full beat.
    function automatic logic [7:0] eth_tkeep_from_rem(input logic [2:0] rem);
        return (rem == 3'd0) ? 8'hFF : ~(8'hFF << rem);
    endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// rtl/bsg_fifo_1r1w_small.sv - small registered one-read one-write FIFO
// Ports: clk_i/reset_i (async active-high), v_i/data_i/ready_o write side,
// v_o/data_o/yumi_i read side (yumi_i pops the head shown on data_o).
// A written entry becomes visible on the read side the following cycle (no bypass).
module bsg_fifo_1r1w_small #(
    parameter int width_p = 64,
    parameter int els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int ptr_width_lp = $clog2(els_p);

    logic [width_p-1:0]    mem [els_p];
    // Pointers carry one extra wrap bit to tell full from empty.
    logic [ptr_width_lp:0] wptr;
    logic [ptr_width_lp:0] rptr;
    logic                  full;
    logic                  push;
    logic                  pop;

    assign full    = (wptr[ptr_width_lp] != rptr[ptr_width_lp])
                   && (wptr[ptr_width_lp-1:0] == rptr[ptr_width_lp-1:0]);
    assign ready_o = ~full;
    assign v_o     = (wptr != rptr);
    assign data_o  = mem[rptr[ptr_width_lp-1:0]];
    assign push    = v_i & ready_o;
    assign pop     = yumi_i & v_o;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + {{ptr_width_lp{1'b0}}, 1'b1};
            end
            if (pop) begin
                rptr <= rptr + {{ptr_width_lp{1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wptr[ptr_width_lp-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/eth_tx_dma_reader.sv
// rtl/eth_tx_dma_reader.sv - descriptor-driven memory reader streaming one AXIS frame
// Ports: clk_i, reset_i (async active-high);
//   descriptor: desc_addr_i, desc_len_i, desc_v_i, desc_ready_o;
//   memory read request: rd_addr_o, rd_v_o, rd_yumi_i; response: rd_data_i, rd_v_i;
//   AXIS out: tx_axis_tdata_o/tkeep_o/tvalid_o/tready_i/tlast_o/tuser_o;
//   status: busy_o, done_o (one-cycle pulse), err_o (sticky until next descriptor).
module eth_tx_dma_reader
    import eth_tx_dma_reader_pkg::*;
#(
    parameter int paddr_width_p     = 40,
    parameter int axis_data_width_p = 64,
    parameter int len_width_p       = 11,
    parameter int max_outstanding_p = 4
) (
    input  logic                         clk_i,
    input  logic                         reset_i,

    input  logic [paddr_width_p-1:0]     desc_addr_i,
    input  logic [len_width_p-1:0]       desc_len_i,
    input  logic                         desc_v_i,
    output logic                         desc_ready_o,

    output logic [paddr_width_p-1:0]     rd_addr_o,
    output logic                         rd_v_o,
    input  logic                         rd_yumi_i,
    input  logic [axis_data_width_p-1:0] rd_data_i,
    input  logic                         rd_v_i,

    output logic [axis_data_width_p-1:0] tx_axis_tdata_o,
    output logic [7:0]                   tx_axis_tkeep_o,
    output logic                         tx_axis_tvalid_o,
    input  logic                         tx_axis_tready_i,
    output logic                         tx_axis_tlast_o,
    output logic                         tx_axis_tuser_o,

    output logic                         busy_o,
    output logic                         done_o,
    output logic                         err_o
);

    localparam int cnt_width_lp  = len_width_p - 2;
    localparam int cred_width_lp = $clog2(max_outstanding_p + 1);

    eth_tx_dma_state_e          state;
    logic [paddr_width_p-1:0]   addr;
    logic [cnt_width_lp-1:0]    words;
    logic [cnt_width_lp-1:0]    req_cnt;
    logic [cnt_width_lp-1:0]    beat_cnt;
    logic [2:0]                 rem;
    logic [cred_width_lp-1:0]   credits;
    logic [cred_width_lp-1:0]   pending;
    logic                       err;

    logic [len_width_p:0]       len_round;
    logic [cnt_width_lp-1:0]    words_n;
    logic                       accept;
    logic                       issue;
    logic                       beat;
    logic                       last_beat;
    logic                       resp_ok;
    logic                       stray;
    logic                       fifo_v;
    logic                       fifo_ready;
    logic [axis_data_width_p-1:0] fifo_data;

    // ceil(len / 8) with one spare bit so 2047 + 7 does not wrap.
    assign len_round = {1'b0, desc_len_i} + (len_width_p + 1)'(eth_dword_bytes_gp - 1);
    assign words_n   = len_round[len_width_p:3];

    assign desc_ready_o = (state == e_idle);
    assign accept       = desc_v_i & desc_ready_o;

    assign rd_v_o    = (state == e_run) && (req_cnt < words) && (credits != '0);
    assign rd_addr_o = addr;
    assign issue     = rd_v_o & rd_yumi_i;

    // A response is only meaningful while some request is still unanswered.
    assign resp_ok = rd_v_i & (pending != '0);
    assign stray   = rd_v_i & (pending == '0);

    assign tx_axis_tvalid_o = (state == e_run) & fifo_v;
    assign tx_axis_tdata_o  = fifo_data;
    assign beat             = tx_axis_tvalid_o & tx_axis_tready_i;
    assign last_beat        = (beat_cnt == (words - cnt_width_lp'(1)));
    assign tx_axis_tlast_o  = tx_axis_tvalid_o & last_beat;
    assign tx_axis_tkeep_o  = !tx_axis_tvalid_o ? 8'h00
                            : last_beat         ? eth_tkeep_from_rem(rem)
                            :                     8'hFF;
    assign tx_axis_tuser_o  = 1'b0;

    assign busy_o = (state == e_run);
    assign done_o = (state == e_done);
    assign err_o  = err;

    bsg_fifo_1r1w_small #(
        .width_p (axis_data_width_p),
        .els_p   (max_outstanding_p)
    ) resp_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (resp_ok & fifo_ready),
        .data_i  (rd_data_i),
        .ready_o (fifo_ready),
        .v_o     (fifo_v),
        .data_o  (fifo_data),
        .yumi_i  (beat)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state    <= e_idle;
            addr     <= '0;
            words    <= '0;
            rem      <= '0;
            req_cnt  <= '0;
            beat_cnt <= '0;
            credits  <= '0;
            pending  <= '0;
            err      <= 1'b0;
        end else begin
            // Unanswered-request count, kept in every state so a stray
            // response is recognised even while idle.
            case ({issue, resp_ok})
                2'b10:   pending <= pending + cred_width_lp'(1);
                2'b01:   pending <= pending - cred_width_lp'(1);
                default: pending <= pending;
            endcase

            if (accept) begin
                err <= (desc_addr_i[2:0] != 3'b000) | stray;
            end else if (stray) begin
                err <= 1'b1;
            end

            unique case (state)
                e_idle: begin
                    if (accept) begin
                        addr     <= {desc_addr_i[paddr_width_p-1:3], 3'b000};
                        words    <= words_n;
                        rem      <= desc_len_i[2:0];
                        req_cnt  <= '0;
                        beat_cnt <= '0;
                        credits  <= cred_width_lp'(max_outstanding_p);
                        state    <= (desc_len_i == '0) ? e_done : e_run;
                    end
                end
                e_run: begin
                    if (issue) begin
                        addr    <= addr + paddr_width_p'(eth_dword_bytes_gp);
                        req_cnt <= req_cnt + cnt_width_lp'(1);
                    end
                    // Credits return when a beat leaves, not when data arrives,
                    // so buffered plus in-flight never exceeds the FIFO depth.
                    case ({issue, beat})
                        2'b10:   credits <= credits - cred_width_lp'(1);
                        2'b01:   credits <= credits + cred_width_lp'(1);
                        default: credits <= credits;
                    endcase
                    if (beat) begin
                        beat_cnt <= beat_cnt + cnt_width_lp'(1);
                        if (last_beat) begin
                            state <= e_done;
                        end
                    end
                end
                e_done: begin
                    state <= e_idle;
                end
                default: begin
                    state <= e_idle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_dma_reader.sv
// tb/tb_eth_tx_dma_reader.sv - directed self-checking bench for eth_tx_dma_reader
module tb_eth_tx_dma_reader;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [39:0] desc_addr_i;
    logic [10:0] desc_len_i;
    logic        desc_v_i;
    logic        desc_ready_o;
    logic [39:0] rd_addr_o;
    logic        rd_v_o;
    logic        rd_yumi_i;
    logic [63:0] rd_data_i;
    logic        rd_v_i;
    logic [63:0] tx_axis_tdata_o;
    logic [7:0]  tx_axis_tkeep_o;
    logic        tx_axis_tvalid_o;
    logic        tx_axis_tready_i;
    logic        tx_axis_tlast_o;
    logic        tx_axis_tuser_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    eth_tx_dma_reader dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .desc_addr_i      (desc_addr_i),
        .desc_len_i       (desc_len_i),
        .desc_v_i         (desc_v_i),
        .desc_ready_o     (desc_ready_o),
        .rd_addr_o        (rd_addr_o),
        .rd_v_o           (rd_v_o),
        .rd_yumi_i        (rd_yumi_i),
        .rd_data_i        (rd_data_i),
        .rd_v_i           (rd_v_i),
        .tx_axis_tdata_o  (tx_axis_tdata_o),
        .tx_axis_tkeep_o  (tx_axis_tkeep_o),
        .tx_axis_tvalid_o (tx_axis_tvalid_o),
        .tx_axis_tready_i (tx_axis_tready_i),
        .tx_axis_tlast_o  (tx_axis_tlast_o),
        .tx_axis_tuser_o  (tx_axis_tuser_o),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .err_o            (err_o)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [39:0] addr;
        int          due;
    } mem_t;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    mem_t        mem_q[$];
    logic [39:0] req_q[$];
    beat_t       beat_q[$];

    int yumi_pct   = 100;
    int tready_pct = 100;
    int max_lat    = 0;
    int stray_cnt  = 0;
    int stray_seen = 0;
    int done_cnt   = 0;
    int first_rdv  = -1;
    int stab_bad   = 0;
    int acc_cyc    = 0;
    int done_cyc   = 0;
    int n_cmp      = 0;
    int n_bad      = 0;

    logic        prev_rdv, prev_yumi, prev_tv, prev_tr, prev_last;
    logic [39:0] prev_addr;
    logic [63:0] prev_data;
    logic [7:0]  prev_keep;

    // Memory and sink model: everything is decided at the falling edge so the
    // rising edge sees settled inputs and outputs.
    initial begin
        rd_yumi_i        = 1'b0;
        rd_v_i           = 1'b0;
        rd_data_i        = '0;
        tx_axis_tready_i = 1'b0;
        prev_rdv = 1'b0; prev_yumi = 1'b0; prev_tv = 1'b0; prev_tr = 1'b0;
        prev_last = 1'b0; prev_addr = '0; prev_data = '0; prev_keep = '0;
        forever begin
            @(negedge clk);
            if (reset_i) begin
                mem_q.delete();
                rd_yumi_i        = 1'b0;
                rd_v_i           = 1'b0;
                tx_axis_tready_i = 1'b0;
                prev_rdv         = 1'b0;
                prev_tv          = 1'b0;
            end else begin
                if (prev_rdv && !prev_yumi && (!rd_v_o || rd_addr_o != prev_addr))
                    stab_bad++;
                if (prev_tv && !prev_tr && (!tx_axis_tvalid_o || tx_axis_tdata_o != prev_data
                        || tx_axis_tkeep_o != prev_keep || tx_axis_tlast_o != prev_last))
                    stab_bad++;
                rd_v_i = 1'b0;
                if (stray_seen != stray_cnt) begin
                    stray_seen = stray_cnt;
                    rd_v_i     = 1'b1;
                    rd_data_i  = 64'hDEAD_BEEF;
                end else if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
                    rd_v_i    = 1'b1;
                    rd_data_i = 64'(mem_q[0].addr);
                    void'(mem_q.pop_front());
                end
                rd_yumi_i        = rd_v_o && (int'($urandom_range(99)) < yumi_pct);
                tx_axis_tready_i = (int'($urandom_range(99)) < tready_pct);
                if (rd_v_o && first_rdv < 0)
                    first_rdv = cyc;
                if (rd_v_o && rd_yumi_i) begin
                    req_q.push_back(rd_addr_o);
                    mem_q.push_back('{addr: rd_addr_o,
                                      due: cyc + 1 + int'($urandom_range(max_lat))});
                end
                if (tx_axis_tvalid_o && tx_axis_tready_i)
                    beat_q.push_back('{data: tx_axis_tdata_o, keep: tx_axis_tkeep_o,
                                       last: tx_axis_tlast_o});
                if (done_o)
                    done_cnt++;
                prev_rdv  = rd_v_o;
                prev_yumi = rd_yumi_i;
                prev_addr = rd_addr_o;
                prev_tv   = tx_axis_tvalid_o;
                prev_tr   = tx_axis_tready_i;
                prev_data = tx_axis_tdata_o;
                prev_keep = tx_axis_tkeep_o;
                prev_last = tx_axis_tlast_o;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string where);
        chk({where, "_desc_ready"}, 64'(desc_ready_o),     64'd1);
        chk({where, "_rd_v"},       64'(rd_v_o),           64'd0);
        chk({where, "_tvalid"},     64'(tx_axis_tvalid_o), 64'd0);
        chk({where, "_tlast"},      64'(tx_axis_tlast_o),  64'd0);
        chk({where, "_tkeep"},      64'(tx_axis_tkeep_o),  64'd0);
        chk({where, "_busy"},       64'(busy_o),           64'd0);
        chk({where, "_done"},       64'(done_o),           64'd0);
        chk({where, "_err"},        64'(err_o),            64'd0);
    endtask

    task automatic start_frame(input logic [39:0] a, input logic [10:0] l);
        req_q.delete();
        beat_q.delete();
        done_cnt  = 0;
        first_rdv = -1;
        stab_bad  = 0;
        @(negedge clk);
        chk("idle_ready", 64'(desc_ready_o), 64'd1);
        desc_addr_i = a;
        desc_len_i  = l;
        desc_v_i    = 1'b1;
        acc_cyc     = cyc;
    endtask

    task automatic wait_done(input int bound);
        int  n    = 0;
        bit  seen = 1'b0;
        while (!seen && n < bound) begin
            @(negedge clk);
            desc_v_i = 1'b0;
            n++;
            if (done_o) begin
                seen     = 1'b1;
                done_cyc = cyc;
            end
        end
        chk("done_seen", 64'(seen), 64'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_frame(input string name, input logic [39:0] exp_base,
                               input int exp_words, input logic [7:0] last_keep,
                               input logic exp_err);
        logic [63:0] exp_a;
        logic [8:0]  got_kl;
        logic [8:0]  exp_kl;
        chk({name, "_req_count"}, 64'(req_q.size()), 64'(exp_words));
        for (int i = 0; i < req_q.size() && i < exp_words; i++) begin
            exp_a = 64'(exp_base) + 64'(8 * i);
            chk($sformatf("%s_req_addr[%0d]", name, i), 64'(req_q[i]), exp_a);
        end
        chk({name, "_beat_count"}, 64'(beat_q.size()), 64'(exp_words));
        for (int i = 0; i < beat_q.size() && i < exp_words; i++) begin
            exp_a  = 64'(exp_base) + 64'(8 * i);
            got_kl = {beat_q[i].last, beat_q[i].keep};
            exp_kl = (i == exp_words - 1) ? {1'b1, last_keep} : {1'b0, 8'hFF};
            chk($sformatf("%s_data[%0d]", name, i), beat_q[i].data, exp_a);
            chk($sformatf("%s_last_keep[%0d]", name, i), 64'(got_kl), 64'(exp_kl));
        end
        chk({name, "_done_pulses"}, 64'(done_cnt), 64'd1);
        chk({name, "_stable"},      64'(stab_bad), 64'd0);
        chk({name, "_err"},         64'(err_o),    64'(exp_err));
        chk({name, "_busy_after"},  64'(busy_o),   64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i     = 1'b1;
        desc_addr_i = '0;
        desc_len_i  = '0;
        desc_v_i    = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        reset_i = 1'b0;
        repeat (2) @(negedge clk);

        // 64 bytes, ideal memory and sink: 8 beats back to back.
        start_frame(40'h8000, 11'd64);
        wait_done(200);
        chk("len64_first_rdv", 64'(first_rdv - acc_cyc), 64'd1);
        chk("len64_latency",   64'(done_cyc - acc_cyc),  64'd11);
        check_frame("len64", 40'h8000, 8, 8'hFF, 1'b0);

        start_frame(40'h9000, 11'd61);
        wait_done(200);
        check_frame("len61", 40'h9000, 8, 8'h1F, 1'b0);

        start_frame(40'hA000, 11'd1);
        wait_done(200);
        chk("len1_latency", 64'(done_cyc - acc_cyc), 64'd4);
        check_frame("len1", 40'hA000, 1, 8'h01, 1'b0);

        start_frame(40'hA800, 11'd0);
        wait_done(200);
        chk("len0_latency", 64'(done_cyc - acc_cyc), 64'd1);
        chk("len0_first_rdv", 64'(first_rdv), 64'hFFFF_FFFF_FFFF_FFFF);
        check_frame("len0", 40'hA800, 0, 8'hFF, 1'b0);

        // Sink stalled: only as many reads as buffer slots may go out.
        tready_pct = 0;
        start_frame(40'hB000, 11'd64);
        repeat (20) @(negedge clk);
        desc_v_i = 1'b0;
        chk("stall_req_count", 64'(req_q.size()), 64'd4);
        chk("stall_rd_v",      64'(rd_v_o),           64'd0);
        chk("stall_tvalid",    64'(tx_axis_tvalid_o), 64'd1);
        tready_pct = 100;
        wait_done(200);
        check_frame("stall", 40'hB000, 8, 8'hFF, 1'b0);

        // Misaligned start: address rounded down, err_o raised.
        start_frame(40'hC004, 11'd16);
        wait_done(200);
        check_frame("misalign", 40'hC000, 2, 8'hFF, 1'b1);

        // Full-size frame under random backpressure and latency.
        yumi_pct   = 60;
        tready_pct = 50;
        max_lat    = 10;
        start_frame(40'h20000, 11'd1514);
        wait_done(20000);
        check_frame("len1514", 40'h20000, 190, 8'h03, 1'b0);

        // Reset in the middle of a frame, then a stray response.
        yumi_pct   = 100;
        tready_pct = 100;
        max_lat    = 0;
        start_frame(40'h30000, 11'd256);
        repeat (8) @(negedge clk);
        desc_v_i = 1'b0;
        chk("midframe_busy", 64'(busy_o), 64'd1);
        reset_i = 1'b1;
        #1;
        chk_reset_outputs("midreset");
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
        @(negedge clk);
        stray_cnt++;
        repeat (3) @(negedge clk);
        chk("stray_err",    64'(err_o),            64'd1);
        chk("stray_tvalid", 64'(tx_axis_tvalid_o), 64'd0);
        chk("stray_ready",  64'(desc_ready_o),     64'd1);

        start_frame(40'h40000, 11'd8);
        wait_done(200);
        check_frame("after_reset", 40'h40000, 1, 8'hFF, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
